// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Shares one AXI4 read master (AR/R) between instruction fetch (req 0) and
// data load (req 1). Round-robin grant, one burst in flight. Requester byte
// offsets are rebased by dram_base, which is captured at accept.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   dram_base, hold       address base / "grant no new bursts"
//   req_ar*               per-requester AR request (offset, len) and accept
//   req_r*                per-requester R beat; data/last/resp are shared
//   M_AR*, M_R*           AXI4 read master toward DRAM
//   busy                  FSM not IDLE
//   err_last              sticky: RLAST disagreed with the beat count
//   grant_cnt             per-requester accepted-burst counters, 32 bits each
//
// Optional feature: define AXI_RD_ARB_PERF_EN to build the grant counters;
// otherwise grant_cnt is tied to zero.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   dram_base,
  input  logic                hold,
  input  logic [1:0]          req_arvalid,
  output logic [1:0]          req_arready,
  input  logic [2*ADDR_W-1:0] req_araddr,
  input  logic [15:0]         req_arlen,
  output logic [1:0]          req_rvalid,
  input  logic [1:0]          req_rready,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                req_rlast,
  output logic [1:0]          req_rresp,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic [7:0]          M_ARLEN,
  output logic [2:0]          M_ARSIZE,
  output logic [1:0]          M_ARBURST,
  input  logic                M_RVALID,
  output logic                M_RREADY,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic                M_RLAST,
  input  logic [1:0]          M_RRESP,
  output logic                busy,
  output logic                err_last,
  output logic [63:0]         grant_cnt
);

  localparam int SIZE = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                gnt_q, gnt_d;
  logic                arvalid_q, arvalid_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beats_q, beats_d;
  logic                grant_g;
  logic [ADDR_W-1:0]   sel_off;
  logic [7:0]          sel_len;

  // Lone requester wins; on contention the priority pointer decides.
  assign grant_g = (req_arvalid == 2'b11) ? prio_q : req_arvalid[1];
  assign sel_off = grant_g ? req_araddr[2*ADDR_W-1:ADDR_W] : req_araddr[ADDR_W-1:0];
  assign sel_len = grant_g ? req_arlen[15:8] : req_arlen[7:0];

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    arvalid_d   = arvalid_q;
    err_d       = err_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beats_d     = beats_q;
    req_arready = 2'b00;
    req_rvalid  = 2'b00;
    M_RREADY    = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset gating keeps a requester from seeing a handshake that the
        // state register is about to discard.
        if (!ARESET && !hold && (req_arvalid != 2'b00)) begin
          req_arready = grant_g ? 2'b10 : 2'b01;
          addr_d      = dram_base + sel_off;  // carry out dropped
          len_d       = sel_len;
          beats_d     = sel_len;
          gnt_d       = grant_g;
          prio_d      = ~grant_g;
          arvalid_d   = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (M_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!ARESET) begin
          M_RREADY          = req_rready[gnt_q];
          req_rvalid[gnt_q] = M_RVALID;
          if (M_RVALID && req_rready[gnt_q]) begin
            beats_d = (beats_q != 8'd0) ? beats_q - 8'd1 : 8'd0;
            // RLAST alone ends the burst; a count disagreement is only flagged.
            if ((M_RLAST && beats_q != 8'd0) || (!M_RLAST && beats_q == 8'd0)) begin
              err_d = 1'b1;
            end
            if (M_RLAST) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      beats_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beats_q   <= beats_d;
    end
  end

  assign M_ARVALID = arvalid_q;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = len_q;
  assign M_ARSIZE  = 3'(SIZE);
  assign M_ARBURST = 2'b01;
  assign req_rdata = M_RDATA;
  assign req_rlast = M_RLAST;
  assign req_rresp = M_RRESP;
  assign busy      = (state_q != IDLE);
  assign err_last  = err_q;

`ifdef AXI_RD_ARB_PERF_EN
  // req_arready is one-hot exactly on an accept, so it doubles as the
  // per-requester increment strobe.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_q;
      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          cnt_q <= 32'd0;
        end else if (req_arready[gi]) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
      assign grant_cnt[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`else
  assign grant_cnt = 64'd0;
`endif

endmodule
